// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instructions into 32-bit machine words
// and writes them into instruction memory, one word per address from 0.
// Each program ends with an all-zero terminator word.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               pulse: begin a new program at address 0
//   in_valid/in_ready   instruction handshake
//   op_sel              operation selector (NOP..END)
//   rs, rt, rd, shamt   register / shift fields
//   imm                 immediate for ADDI/LW/SW
//   target              absolute word target for BEQ/BNE/JAL
//   imem_we/imem_ready  back-pressured memory write handshake
//   imem_addr/wdata     write address and encoded word
//   word_count          words written in this program, terminator included
//   done                terminator written
//   error               non-END instruction arrived at the reserved last slot
module instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LOAD, TERM, DONE, ERR} state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
    OP_JR, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_END
  } op_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state;
  op_e               op;
  logic [ADDR_W-1:0] addr;      // next free slot
  logic [ADDR_W-1:0] eff_addr;  // slot an instruction accepted this cycle lands in
  logic              complete;
  logic              accept;
  logic [15:0]       off;
  logic [31:0]       enc_word;

  assign op       = op_e'(op_sel);
  assign complete = imem_we && imem_ready;
  assign in_ready = (state == LOAD) && (!imem_we || imem_ready);
  assign accept   = in_valid && in_ready && !start;

  // A write completing on the same edge as an acceptance frees the slot,
  // so the new instruction goes to the following address.
  assign eff_addr = complete ? addr + ADDR_W'(1) : addr;

  // Branch offset relative to the delay-slot address, modulo 2^16.
  assign off = 16'(target) - 16'(eff_addr) - 16'd1;

  always_comb begin
    enc_word = '0;
    unique case (op)
      OP_NOP:  enc_word = '0;
      OP_ADD:  enc_word = {6'b0, rs, rt, rd, 5'b0, 6'b100000};
      OP_SUB:  enc_word = {6'b0, rs, rt, rd, 5'b0, 6'b100010};
      OP_AND:  enc_word = {6'b0, rs, rt, rd, 5'b0, 6'b100100};
      OP_OR:   enc_word = {6'b0, rs, rt, rd, 5'b0, 6'b100101};
      OP_SLT:  enc_word = {6'b0, rs, rt, rd, 5'b0, 6'b101010};
      OP_SLL:  enc_word = {6'b0, 5'b0, rt, rd, shamt, 6'b000000};
      OP_SRL:  enc_word = {6'b0, 5'b0, rt, rd, shamt, 6'b000010};
      OP_JR:   enc_word = {6'b0, rs, 15'b0, 6'b001000};
      OP_ADDI: enc_word = {6'b001000, rs, rt, imm};
      OP_LW:   enc_word = {6'b100011, rs, rt, imm};
      OP_SW:   enc_word = {6'b101011, rs, rt, imm};
      OP_BEQ:  enc_word = {6'b000100, rs, rt, off};
      OP_BNE:  enc_word = {6'b000101, rs, rt, off};
      OP_JAL:  enc_word = {6'b000011, 26'(target)};
      OP_END:  enc_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (start) begin
      state      <= LOAD;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (complete) begin
        addr       <= addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      case (state)
        LOAD: begin
          if (accept) begin
            if (op == OP_END) begin
              imem_we    <= 1'b1;
              imem_addr  <= eff_addr;
              imem_wdata <= '0;
              state      <= TERM;
            end else if (eff_addr == LAST) begin
              imem_we <= 1'b0;
              error   <= 1'b1;
              state   <= ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= eff_addr;
              imem_wdata <= enc_word;
            end
          end else if (complete) begin
            imem_we <= 1'b0;
          end
        end
        TERM: begin
          if (complete) begin
            imem_we <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader for the pipelined MIPS core: the inverse of the decode stage. It accepts symbolic instructions (operation selector plus register, shift, immediate and target fields) over a valid/ready handshake and produces 32-bit MIPS machine words. It computes branch offsets from absolute word targets and writes the words sequentially into instruction memory through a back-pressured write port. It closes each program with the all-zero terminator word that the decode stage treats as the print/stop marker.

## Interface
- ADDR_W, 10: instruction-memory word-address width; legal range 2..15.
- DEPTH, 2**ADDR_W: number of memory words; the last word is reserved for the terminator.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new program at address 0.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- op_sel  in  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 SRL, 8 JR, 9 ADDI, 10 LW, 11 SW, 12 BEQ, 13 BNE, 14 JAL, 15 END.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate for ADDI, LW, SW.
- target  in  ADDR_W  absolute word address for BEQ, BNE, JAL.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- word_count  out  ADDR_W+1  words written in the current program, terminator included.
- done  out  1  terminator has been written.
- error  out  1  overflow: a non-END instruction arrived at the reserved last slot.

## Operation
- States: IDLE, LOAD, TERM, DONE, ERR. Reset enters IDLE.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, done=0, error=0.
- start from any state: next state LOAD; address, word_count, done and error cleared; any pending write dropped (imem_we=0).
- in_ready = (state==LOAD) && (!imem_we || imem_ready).
- Encodings, with all unused fields zero:
  - NOP: 32'h00000000. It is a non-terminating SLL $0 and counts as an ordinary word.
  - ADD, SUB, AND, OR, SLT: {6'b0, rs, rt, rd, 5'b0, funct}. funct values: 100000, 100010, 100100, 100101, 101010.
  - SLL and SLR: {6'b0, 5'b0, rt, rd, shamt, funct}. funct values: 000000 (SLL), 000010 (SRL).
  - JR: {6'b0, rs, 15'b0, 6'b001000}.
  - ADDI, LW, SW: {op, rs, rt, imm}. op values: 001000, 100011, 101011.
  - BEQ, BNE: {op, rs, rt, off}. op values: 000100, 000101. off = target − (addr+1), sign-extended to 16 bits and computed modulo 2^16. A backward target is negative.
  - JAL: {6'b000011, 26-bit zero-extended target}.
- END accepted in LOAD: the all-zero word is written at the current address, state goes to TERM, and done rises when that write completes.
- Non-END accepted with address == DEPTH−1: nothing is written, error=1, state ERR, in_ready=0. The state is held until start or reset.
- Address and word_count increment on each completed write (imem_we && imem_ready). There is no wrap: the reserved slot prevents it.

## Timing
- Acceptance at edge N (in_valid && in_ready). After edge N: imem_we=1, with imem_addr and imem_wdata valid.
- The write completes at the first edge where imem_ready=1. Outputs hold stable until then.
- Throughput is one word per cycle with imem_ready tied high. This works because a completing write and a new acceptance can share an edge.
- Latency from acceptance to data on the port is 1 cycle.
- done and word_count update at the edge of the terminator's completing write. done stays high in DONE until start or reset.
- error rises at the edge that accepts the offending instruction.
- Simultaneous start and in_valid: start wins, and the instruction is not accepted that cycle (in_ready was 0 outside LOAD, or the pending state is flushed).
- rst_n low mid-write: the write is abandoned and all outputs return to reset values at that edge.

## Test plan
- Reset then start. Feed ADD rs=1 rt=2 rd=3, then END, with imem_ready=1. Required: addr0=32'h00221820, addr1=32'h00000000, word_count=2, done=1.
- Backward branch: ADDI rs=0 rt=1 imm=5 at addr 0, then BNE rs=1 rt=0 target=0 at addr 1. Required: addr0=32'h20010005, addr1=32'h1420FFFE.
- Back-pressure: hold imem_ready=0 for 3 cycles during an LW rs=29 rt=8 imm=4. Required: 32'h8FA80004 held stable at addr 0, in_ready=0 throughout, and exactly one write.
- SLL rt=2 rd=2 shamt=4 and JAL target=0x10. Required: 32'h00021100 and 32'h0C000010.
- Overflow with ADDR_W=2: accept 3 ADD instructions, then a 4th ADD. Required: error=1, no write to addr 3, in_ready=0. Then start: error=0 and address 0.
- Reset asserted while imem_we=1 and imem_ready=0. Required: all outputs 0 the next cycle and the state is IDLE.
